// File: rtl/tick_bcd_stopwatch_if.sv
// rtl/tick_bcd_stopwatch_if.sv - stopwatch tick/button/display bundle; lap signals under STOPWATCH_LAP_EN
interface tick_bcd_stopwatch_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    tick_in;
  logic                    start_stop;
  logic                    clear;
  logic [4*NUM_DIGITS-1:0] bcd_out;
  logic                    running;
  logic                    wrap;
`ifdef STOPWATCH_LAP_EN
  logic                    lap;
  logic                    lap_active;
`endif

  modport master (
    output tick_in, start_stop, clear,
    input  bcd_out, running, wrap
`ifdef STOPWATCH_LAP_EN
    , output lap
    , input  lap_active
`endif
  );

  modport slave (
    input  tick_in, start_stop, clear,
    output bcd_out, running, wrap
`ifdef STOPWATCH_LAP_EN
    , input  lap
    , output lap_active
`endif
  );
endinterface

// File: rtl/tick_bcd_stopwatch.sv
// rtl/tick_bcd_stopwatch.sv - BCD stopwatch counting synchronised tick_in edges; lap display under STOPWATCH_LAP_EN
module tick_bcd_stopwatch #(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 1,
  parameter int SATURATE   = 0
) (
  input  logic                 clk,
  input  logic                 resetn,
  tick_bcd_stopwatch_if.slave  sw
);

  localparam int          W         = 4 * NUM_DIGITS;
  localparam logic [7:0]  PCNT_LAST = 8'(PRESCALE - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_t;

  state_t         state_q, state_d;
  logic           s1_q, s2_q, s3_q;
  logic           tick_edge;
  logic [7:0]     pcnt_q, pcnt_d;
  logic [W-1:0]   count_q, count_d;
  logic [W-1:0]   bcd_q, bcd_d;
  logic           running_q, running_d;
  logic           wrap_q, wrap_d;
  logic           inc, all_nines, ovf;
  logic           lap_pulse;
  logic           lap_active_q, lap_active_d;
  logic [W-1:0]   lap_q, lap_d;

  // Decimal ripple increment: each digit rolls 9->0 and carries upward.
  function automatic logic [W-1:0] bcd_incr(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Three-flop synchroniser: tick_in is only ever sampled, never used as a clock.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= sw.tick_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign tick_edge = s2_q & ~s3_q;
  assign inc       = (state_q == RUN) && tick_edge && (pcnt_q == PCNT_LAST);
  assign ovf       = inc && all_nines;

`ifdef STOPWATCH_LAP_EN
  assign lap_pulse = sw.lap;
`else
  assign lap_pulse = 1'b0;
`endif

  // Detect the all-nines count that turns the next increment into an overflow.
  always_comb begin
    all_nines = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (count_q[4*i +: 4] != 4'd9) all_nines = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state: clear dominates; a saturating overflow pauses the watch.
  always_comb begin
    state_d = state_q;
    if (sw.clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (sw.start_stop) state_d = RUN;
        RUN:     if (sw.start_stop || (ovf && (SATURATE != 0))) state_d = PAUSE;
        PAUSE:   if (sw.start_stop) state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath and registered-output next values: prescaler, count, lap, display.
  always_comb begin
    pcnt_d       = pcnt_q;
    count_d      = count_q;
    wrap_d       = 1'b0;
    lap_active_d = lap_active_q;
    lap_d        = lap_q;
    if (sw.clear) begin
      pcnt_d       = 8'd0;
      count_d      = '0;
      lap_active_d = 1'b0;
    end else begin
      if ((state_q == IDLE) && sw.start_stop) begin
        pcnt_d = 8'd0;
      end else if ((state_q == RUN) && tick_edge) begin
        pcnt_d = inc ? 8'd0 : pcnt_q + 8'd1;
      end
      if (inc) begin
        if (all_nines) begin
          wrap_d = 1'b1;
          if (SATURATE == 0) count_d = '0;
        end else begin
          count_d = bcd_incr(count_q);
        end
      end
      if ((state_q == RUN) && lap_pulse) begin
        if (lap_active_q) begin
          lap_active_d = 1'b0;
        end else begin
          lap_active_d = 1'b1;
          lap_d        = count_q;
        end
      end
    end
    bcd_d     = lap_active_d ? lap_d : count_d;
    running_d = (state_d == RUN);
  end

  // Count, prescaler and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pcnt_q       <= 8'd0;
      count_q      <= '0;
      bcd_q        <= '0;
      running_q    <= 1'b0;
      wrap_q       <= 1'b0;
      lap_active_q <= 1'b0;
      lap_q        <= '0;
    end else begin
      pcnt_q       <= pcnt_d;
      count_q      <= count_d;
      bcd_q        <= bcd_d;
      running_q    <= running_d;
      wrap_q       <= wrap_d;
      lap_active_q <= lap_active_d;
      lap_q        <= lap_d;
    end
  end

  assign sw.bcd_out = bcd_q;
  assign sw.running = running_q;
  assign sw.wrap    = wrap_q;
`ifdef STOPWATCH_LAP_EN
  assign sw.lap_active = lap_active_q;
`endif

endmodule
